// File: rtl/fp_accumulator.sv
// rtl/fp_accumulator.sv - packet accumulator front-end for a multicycle combinational FP add/sub unit
// Optional element counter output out_count is built when FP_ACC_COUNT_EN is defined.
module fp_accumulator #(
    parameter int FU_WAIT = 2,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sub,
    input  logic        in_last,
    output logic [31:0] fu_a,
    output logic [31:0] fu_b,
    output logic        fu_as,
    input  logic [31:0] fu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_nan,
    output logic        out_inf
`ifdef FP_ACC_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_count
`endif
);

    generate
        if (FU_WAIT < 1 || FU_WAIT > 15) begin : g_bad_wait
            $error("fp_accumulator: FU_WAIT must be 1..15");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("fp_accumulator: CNT_W must be at least 1");
        end
    endgenerate

    localparam logic [3:0] WAIT_LOAD = 4'(FU_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        WAIT,
        OUT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] acc;
    logic [31:0] op_b;
    logic        op_sub;
    logic        last_r;
    logic        first_flag;
    logic [3:0]  wait_cnt;
    logic        accept;

    assign accept = in_valid & in_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE, ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (first_flag) begin
                        state_next = in_last ? OUT : ACC;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = last_r ? OUT : ACC;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 32'h0000_0000;
            op_b       <= 32'h0000_0000;
            op_sub     <= 1'b1;
            last_r     <= 1'b0;
            first_flag <= 1'b1;
            wait_cnt   <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_b   <= in_data;
                op_sub <= in_sub;
                last_r <= in_last;
                if (first_flag) begin
                    // First element bypasses the adder; subtract is just a sign flip.
                    acc        <= {in_data[31] ^ in_sub, in_data[30:0]};
                    first_flag <= 1'b0;
                end else begin
                    wait_cnt <= WAIT_LOAD;
                end
            end
            if (state == WAIT) begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt <= wait_cnt - 4'd1;
                end else begin
                    acc <= fu_result;
                end
            end
            if (state == OUT && out_ready) begin
                first_flag <= 1'b1;
            end
        end
    end

    // Adder inputs come straight from registers so they stay still across the settle window.
    assign fu_a  = acc;
    assign fu_b  = op_b;
    assign fu_as = op_sub;

    assign out_data = acc;
    assign out_nan  = (&acc[30:23]) & (|acc[22:0]);
    assign out_inf  = (&acc[30:23]) & ~(|acc[22:0]);

`ifdef FP_ACC_COUNT_EN
    logic [CNT_W-1:0] elem_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt <= '0;
        end else if (accept) begin
            if (first_flag) begin
                elem_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (~&elem_cnt) begin
                elem_cnt <= elem_cnt + 1'b1;
            end
        end
    end

    assign out_count = elem_cnt;
`endif

endmodule

// File: tb/tb_fp_accumulator.sv
// tb/tb_fp_accumulator.sv - directed self-checking bench for fp_accumulator
module tb_fp_accumulator;

    localparam int FU_WAIT = 2;
    localparam int CNT_W   = 16;

    localparam logic [31:0] F_1   = 32'h3F80_0000;
    localparam logic [31:0] F_M1  = 32'hBF80_0000;
    localparam logic [31:0] F_2   = 32'h4000_0000;
    localparam logic [31:0] F_M2  = 32'hC000_0000;
    localparam logic [31:0] F_3   = 32'h4040_0000;
    localparam logic [31:0] F_4   = 32'h4080_0000;
    localparam logic [31:0] F_7   = 32'h40E0_0000;
    localparam logic [31:0] F_INF = 32'h7F80_0000;
    localparam logic [31:0] F_NAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sub;
    logic        in_last;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic        fu_as;
    logic [31:0] fu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_nan;
    logic        out_inf;
`ifdef FP_ACC_COUNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Table adder: only the operand combinations the directed tests exercise.
    function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b,
                                                input logic s);
        logic [31:0] r;
        r = 32'hDEAD_BEEF;
        if (!s && a == F_1   && b == F_2) r = F_3;
        if (!s && a == F_3   && b == F_4) r = F_7;
        if (!s && a == F_INF && b == F_1) r = F_INF;
        if (!s && a == F_NAN && b == F_1) r = F_NAN;
        if ( s && a == F_3   && b == F_1) r = F_2;
        return r;
    endfunction

    assign fu_result = adder_model(fu_a, fu_b, fu_as);

    fp_accumulator #(.FU_WAIT(FU_WAIT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_as     (fu_as),
        .fu_result (fu_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nan   (out_nan),
        .out_inf   (out_inf)
`ifdef FP_ACC_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [31:0] d, input logic s, input logic l,
                        output int acc_cyc, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int seen_cyc);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout: out_valid=%0b, required 1", out_valid);
        end
        seen_cyc = cyc;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
        checks++;
        if (fu_a !== 32'h0 || fu_b !== 32'h0 || fu_as !== 1'b1) begin
            errors++;
            $display("FAIL reset_fu: fu_a=%h fu_b=%h fu_as=%0b, required 0 0 1", fu_a, fu_b, fu_as);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_pair;
        int a1, a2, w, e;
        send(F_1, 1'b0, 1'b0, a1, w);
        send(F_2, 1'b0, 1'b1, a2, w);
        for (int i = 0; i < FU_WAIT; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || fu_b !== F_2 || fu_as !== 1'b0) begin
                errors++;
                $display("FAIL pair_wait[%0d]: in_ready=%0b out_valid=%0b fu_b=%h fu_as=%0b, required 0 0 %h 0",
                         i, in_ready, out_valid, fu_b, fu_as, F_2);
            end
        end
        @(negedge clk);
        wait_out(e);
        checks++;
        if (e - a1 + 1 !== FU_WAIT + 2) begin
            errors++;
            $display("FAIL pair_latency: got %0d, required %0d", e - a1 + 1, FU_WAIT + 2);
        end
        checks++;
        if (out_data !== F_3 || out_nan !== 1'b0 || out_inf !== 1'b0) begin
            errors++;
            $display("FAIL pair_data: out_data=%h nan=%0b inf=%0b, required %h 0 0", out_data, out_nan, out_inf, F_3);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pair_one_cycle: out_valid=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_single_sub;
        int a, w, e;
        send(F_1, 1'b1, 1'b1, a, w);
        wait_out(e);
        checks++;
        if (e - a + 1 !== 1 || out_data !== F_M1) begin
            errors++;
            $display("FAIL single_sub: latency=%0d out_data=%h, required 1 %h", e - a + 1, out_data, F_M1);
        end
        @(negedge clk);
    endtask

    task automatic test_three;
        int a1, a2, a3, w2, w3, e;
        send(F_1, 1'b0, 1'b0, a1, w2);
        send(F_2, 1'b0, 1'b0, a2, w2);
        send(F_4, 1'b0, 1'b1, a3, w3);
        checks++;
        if (w2 !== 0 || w3 !== FU_WAIT) begin
            errors++;
            $display("FAIL three_ready: waits=%0d %0d, required 0 %0d", w2, w3, FU_WAIT);
        end
        wait_out(e);
        checks++;
        if (e - a1 + 1 !== 2 * (FU_WAIT + 1) + 1 || out_data !== F_7) begin
            errors++;
            $display("FAIL three_sum: latency=%0d out_data=%h, required %0d %h",
                     e - a1 + 1, out_data, 2 * (FU_WAIT + 1) + 1, F_7);
        end
`ifdef FP_ACC_COUNT_EN
        checks++;
        if (out_count !== 16'd3) begin
            errors++;
            $display("FAIL three_count: out_count=%0d, required 3", out_count);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_sub_pair;
        int a1, a2, w, e;
        send(F_3, 1'b0, 1'b0, a1, w);
        send(F_1, 1'b1, 1'b1, a2, w);
        checks++;
        if (fu_as !== 1'b1 || fu_a !== F_3 || fu_b !== F_1) begin
            errors++;
            $display("FAIL sub_fu: fu_as=%0b fu_a=%h fu_b=%h, required 1 %h %h", fu_as, fu_a, fu_b, F_3, F_1);
        end
        wait_out(e);
        checks++;
        if (out_data !== F_2) begin
            errors++;
            $display("FAIL sub_pair: out_data=%h, required %h", out_data, F_2);
        end
        @(negedge clk);
    endtask

    task automatic test_special;
        int a, w, e;
        send(F_INF, 1'b0, 1'b0, a, w);
        send(F_1, 1'b0, 1'b1, a, w);
        wait_out(e);
        checks++;
        if (out_data !== F_INF || out_inf !== 1'b1 || out_nan !== 1'b0) begin
            errors++;
            $display("FAIL special_inf: out_data=%h inf=%0b nan=%0b, required %h 1 0", out_data, out_inf, out_nan, F_INF);
        end
        @(negedge clk);
        send(F_NAN, 1'b0, 1'b0, a, w);
        send(F_1, 1'b0, 1'b1, a, w);
        wait_out(e);
        checks++;
        if (out_data !== F_NAN || out_nan !== 1'b1 || out_inf !== 1'b0) begin
            errors++;
            $display("FAIL special_nan: out_data=%h nan=%0b inf=%0b, required %h 1 0", out_data, out_nan, out_inf, F_NAN);
        end
        @(negedge clk);
    endtask

    task automatic test_hold;
        int a, w, e;
        out_ready = 1'b0;
        send(F_1, 1'b0, 1'b1, a, w);
        wait_out(e);
        in_valid = 1'b1;
        in_data  = F_4;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== F_1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: out_valid=%0b out_data=%h in_ready=%0b, required 1 %h 0",
                         i, out_valid, out_data, in_ready, F_1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
        send(F_2, 1'b1, 1'b1, a, w);
        wait_out(e);
        checks++;
        if (e - a + 1 !== 1 || out_data !== F_M2) begin
            errors++;
            $display("FAIL hold_next: latency=%0d out_data=%h, required 1 %h", e - a + 1, out_data, F_M2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait;
        int a, w, e;
        send(F_1, 1'b0, 1'b0, a, w);
        send(F_2, 1'b0, 1'b0, a, w);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre: in_ready=%0b, required 0", in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || fu_a !== 32'h0 || fu_b !== 32'h0 || fu_as !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wait: out_valid=%0b in_ready=%0b fu_a=%h fu_b=%h fu_as=%0b, required 0 1 0 0 1",
                     out_valid, in_ready, fu_a, fu_b, fu_as);
        end
`ifdef FP_ACC_COUNT_EN
        checks++;
        if (out_count !== '0) begin
            errors++;
            $display("FAIL rst_count: out_count=%0d, required 0", out_count);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(F_1, 1'b0, 1'b1, a, w);
        wait_out(e);
        checks++;
        if (e - a + 1 !== 1 || out_data !== F_1) begin
            errors++;
            $display("FAIL rst_next: latency=%0d out_data=%h, required 1 %h", e - a + 1, out_data, F_1);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_pair();
        test_single_sub();
        test_three();
        test_sub_pair();
        test_special();
        test_hold();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
Sequential front-end for the combinational single-precision floating-point add/sub unit. It accepts a stream of IEEE-754 operands over a valid/ready handshake and drives the unit's A, B and add/sub inputs from registers. It samples the unit's result after a fixed multicycle settle window and accumulates a running sum per packet. The packet result is then presented on a valid/ready output port.

Parameters:
FU_WAIT, 2, cycles operands are held stable before fu_result is sampled (legal 1..15; multicycle path budget of the adder)
CNT_W, 16, width of element counter (optional feature only)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  block can accept operand
in_data  in  32  IEEE-754 single operand
in_sub  in  1  1 = subtract operand from accumulator, 0 = add
in_last  in  1  operand closes current packet
fu_a  out  32  to adder A (registered accumulator)
fu_b  out  32  to adder B (registered operand)
fu_as  out  1  to adder add/sub select (registered)
fu_result  in  32  adder result (combinational from fu_a/fu_b/fu_as)
out_valid  out  1  packet sum valid
out_ready  in  1  downstream accepts sum
out_data  out  32  packet sum
out_nan  out  1  out_data exponent 0xFF, mantissa != 0
out_inf  out  1  out_data exponent 0xFF, mantissa == 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state IDLE; acc, op_b, fu_a, fu_b = 0x00000000.
  - fu_as, first_flag = 1 (first_flag is in the reset group, reset value 1).
  - wait counter 0; out_valid 0; in_ready 1.
- fu_a = acc register; fu_b = op_b register; fu_as = op_sub register. All three are stable for the whole WAIT window.
- States: IDLE, ACC, WAIT, OUT. in_ready = 1 only in IDLE and ACC.
- Accept: in_valid & in_ready.
  - op_b <= in_data; op_sub <= in_sub; last_r <= in_last.
- First element of packet (first_flag = 1):
  - Adder is bypassed: acc <= {in_data[31]^in_sub, in_data[30:0]}; first_flag <= 0.
  - Next state OUT if in_last, else ACC. No WAIT.
- Later element: next state WAIT; counter loaded with FU_WAIT-1.
- WAIT:
  - Counter decrements each cycle.
  - When counter == 0, acc <= fu_result; next state OUT if last_r, else ACC.
  - in_ready is low for exactly FU_WAIT cycles after the accept.
- OUT:
  - out_valid = 1; out_data, out_nan and out_inf decode from acc and are held stable while out_ready = 0.
  - On out_ready: first_flag <= 1, state IDLE. acc is not cleared; the next first element overwrites it.
- in_valid in WAIT/OUT is ignored; the source must hold it under standard valid/ready rules.
- Simultaneous accept of a first and last element: completes in 1 cycle, out_valid asserted the following cycle.
- No arithmetic inside the block; all add/sub, special-case and rounding behaviour is the adder's.
- Reset mid-WAIT or mid-OUT: immediate return to reset values; the in-flight packet is discarded.
- Latency: packet of N elements, back-to-back input, out_valid rises (N-1)*(FU_WAIT+1)+1 cycles after the first accept.

Optional Feature:
FP_ACC_COUNT_EN:
- Defined: adds output port out_count [CNT_W-1:0], the number of elements in the presented packet.
  - Counter is set to 1 on a first-element accept and increments on each later accept.
  - It saturates at all-ones and is valid with out_valid.
  - Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- 0x3F800000 (1.0, first), then 0x40000000 (2.0, last), add, out_ready=1 -> out_data 0x40400000, out_valid one cycle, in_ready low FU_WAIT cycles after the 2nd accept.
- Single element 0x3F800000 with in_sub=1 and in_last=1 -> out_data 0xBF800000 the next cycle, adder bypassed.
- Three elements 1.0, 2.0, 4.0 (0x40800000, last) -> out_data 0x40E00000; out_valid at cycle 2*(FU_WAIT+1)+1.
- 0x7F800000 then 0x3F800000 last -> out_data 0x7F800000, out_inf=1, out_nan=0; with NaN 0x7FC00000 as the first element -> out_nan=1.
- Hold out_ready=0 for 5 cycles in OUT -> out_valid and out_data stable, in_ready=0; release -> IDLE, next packet starts clean.
- Assert rst_n=0 during WAIT -> out_valid=0, in_ready=1, fu_a=0 asynchronously. With FP_ACC_COUNT_EN, a 3-element packet -> out_count=3.
